sweep_scheduler: RTL and testbench
==================================

// Module: sweep_scheduler
// PURPOSE
//  Sequences the sun-tracking sweep: steps the horizontal, then the vertical servo across its range.
//  At each position it waits a settle time, fires one ADC conversion and records the peak panel voltage and where it occurred.
//  It then drives the servo back to that peak position.
//  Sits between the step-rate tick generator and the XADC (SOC/EOC/data) on one side, and the servo_driver step/direction inputs on the other.
//  Replaces the free-running FSM/counter trio.
// PARAMETERS
//  ADC_W        12    ADC sample width
//  POS_W        8     servo position counter width
//  H_STEPS      180   horizontal positions swept (0..H_STEPS-1), 2..2**POS_W
//  V_STEPS      90    vertical positions swept (0..V_STEPS-1), 2..2**POS_W
//  SETTLE_TICKS 4     TICK pulses waited after a step before sampling, >=1
//  EOC_TIMEOUT  4095  CLK cycles allowed between ADC_SOC and ADC_EOC
// PORTS
//  CLK        in   1      system clock (PLL output)
//  RST_N      in   1      asynchronous reset, active-low
//  TICK       in   1      one-CLK step-rate strobe
//  START      in   1      pulse: begin full sweep (ignored unless IDLE)
//  ABORT      in   1      pulse: stop and return to IDLE
//  ADC_SOC    out  1      one-CLK start-of-conversion pulse
//  ADC_EOC    in   1      one-CLK end-of-conversion pulse
//  ADC_DATA   in   ADC_W  sample, valid when ADC_EOC=1
//  STEP_H     out  1      one-CLK horizontal step request
//  STEP_V     out  1      one-CLK vertical step request
//  DIR_H      out  1      0 = forward (pos++), 1 = backward (pos--)
//  DIR_V      out  1      as DIR_H for the vertical axis
//  BUSY       out  1      high in every state except IDLE
//  DONE       out  1      one-CLK pulse when the sweep completes normally
//  ERR        out  1      sticky EOC-timeout flag, cleared by START
//  MAX_V      out  ADC_W  peak sample of the current/last sweep
//  MAX_H_POS  out  POS_W  horizontal position of the peak
//  MAX_V_POS  out  POS_W  vertical position of the peak (vertical phase only)
//  STAT       out  3      state code (below)
// BEHAVIOUR
//  Reset: all outputs 0, pos_h = pos_v = 0, state IDLE.
//  Servos are at position 0 at reset/START; the block tracks position internally.
//  States and STAT codes:
//   IDLE=0, SETTLE=1, SAMPLE=2, WAIT_EOC=3, STEP=4, RETURN=5, FINISH=6.
//   A phase bit selects the H or V axis.
//  IDLE --START--> SETTLE (phase H): clear MAX_V, MAX_*_POS and ERR; zero the settle counter.
//  SETTLE: count TICKs; on the SETTLE_TICKS-th TICK go to SAMPLE.
//  SAMPLE: assert ADC_SOC for exactly 1 CLK, then go to WAIT_EOC.
//  WAIT_EOC: ADC_EOC in the same cycle as ADC_SOC is ignored.
//   On ADC_EOC: if ADC_DATA > MAX_V (strict), latch MAX_V and the current axis position into MAX_*_POS. Ties keep the earlier position.
//   Then, if pos < STEPS-1, go to STEP; else go to RETURN.
//   If EOC_TIMEOUT cycles elapse without EOC: set ERR, go to IDLE (no DONE).
//  STEP: on the next TICK pulse STEP_x with DIR_x=0, pos++, then go to SETTLE.
//  RETURN: on each TICK, if pos > MAX_x_POS pulse STEP_x with DIR_x=1 and pos--.
//   When pos == MAX_x_POS: in phase H, switch to phase V and go to SETTLE; in phase V, go to FINISH.
//  MAX_V carries over from the H phase into the V phase.
//   Therefore MAX_V_POS stays 0 (servo stays home) unless a V sample strictly exceeds the H peak.
//  FINISH: DONE=1 for 1 CLK, then IDLE. pos_h/pos_v hold the peak position; MAX_* hold until next START.
//  At most one STEP pulse per TICK. STEP_H and STEP_V are never both high.
//  DIR_x is valid in the same cycle as STEP_x and holds its value between steps.
//  ABORT has priority over all transitions, including the cycle START is accepted.
//   Effect: go to IDLE next cycle; drop BUSY; no SOC/STEP/DONE pulses; MAX_* and pos retained.
//   The next START re-sweeps from the current pos (pos counters are not reset).
//  START while BUSY is ignored. START and ABORT in the same cycle: ABORT wins.
//  TICK arriving in a non-TICK state (SAMPLE, WAIT_EOC) is dropped, not queued.
//  Counters: settle counter width clog2(SETTLE_TICKS+1); timeout counter width clog2(EOC_TIMEOUT+1). No wrap; pos is bounded by STEPS-1 and 0.
// STRUCTURE
//  Shared package sp_pkg: state localparams with STAT codes, ADC_W default, and the DIR_FWD/DIR_BWD constants.
//  One sub-module: axis_tracker (pos counter, peak-position register, step/dir outputs), instanced per axis.
//  FSM, settle counter and timeout counter live in the top.
// TESTING
//  1 Reset, then START; H_STEPS=4, V_STEPS=3, SETTLE_TICKS=2; ADC returns 100,300,300,200 (H), then 50,400,10 (V):
//    expect MAX_H_POS=1, MAX_V_POS=1, MAX_V=400, DONE once, 2 backward STEP_H pulses, 1 backward STEP_V pulse.
//  2 Flat data (all 500): expect MAX_H_POS=0, MAX_V_POS=0, return steps H=3, V=2.
//  3 Withhold ADC_EOC after the 2nd SOC: after EOC_TIMEOUT cycles expect ERR=1, STAT=0, BUSY=0, no DONE.
//  4 ABORT during STEP: expect no STEP pulse, IDLE next CLK, MAX_V retained.
//    Then START: ERR cleared and MAX_V=0.
//  5 START pulsed while BUSY and ADC_EOC coincident with ADC_SOC: both ignored; sampling waits for the next EOC.
//  6 Assert RST_N low mid-WAIT_EOC: all outputs 0 immediately (asynchronously); after release STAT=0.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared definitions for the sun-tracking sweep scheduler: state/STAT codes,
// axis phase select, servo direction encoding and default widths.
package sp_pkg;

  localparam int unsigned ADC_W_DEF = 12;
  localparam int unsigned STAT_W    = 3;

  // State encoding doubles as the externally visible STAT code.
  typedef enum logic [STAT_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_SAMPLE   = 3'd2,
    ST_WAIT_EOC = 3'd3,
    ST_STEP     = 3'd4,
    ST_RETURN   = 3'd5,
    ST_FINISH   = 3'd6
  } state_e;

  // Which servo axis the sweep is currently driving.
  typedef enum logic {
    PH_H = 1'b0,
    PH_V = 1'b1
  } phase_e;

  localparam logic DIR_FWD = 1'b0;  // pos++
  localparam logic DIR_BWD = 1'b1;  // pos--

endpackage

// File: rtl/axis_tracker.sv
// Per-axis servo bookkeeping: position counter, peak-position register and the
// registered step/direction outputs that feed the servo driver.
//   clk_i, rst_ni : clock, async active-low reset
//   fwd_i         : request one forward step (pos++)
//   bwd_i         : request one backward step (pos--)
//   capture_i     : latch current position as the peak position
//   clear_i       : zero the peak position (new sweep)
//   pos_o         : tracked servo position
//   peak_o        : position of the recorded peak
//   step_o/dir_o  : one-cycle step pulse and its direction (dir holds between steps)
module axis_tracker
  import sp_pkg::*;
#(
  parameter int unsigned POS_W = 8,
  parameter int unsigned STEPS = 180
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fwd_i,
  input  logic             bwd_i,
  input  logic             capture_i,
  input  logic             clear_i,
  output logic [POS_W-1:0] pos_o,
  output logic [POS_W-1:0] peak_o,
  output logic             step_o,
  output logic             dir_o
);

  localparam logic [POS_W-1:0] LAST = POS_W'(STEPS - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] peak_q, peak_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;

  // Position is clamped to 0..STEPS-1; a step is only emitted when it moves.
  always_comb begin
    pos_d  = pos_q;
    peak_d = peak_q;
    step_d = 1'b0;
    dir_d  = dir_q;
    if (fwd_i && (pos_q < LAST)) begin
      pos_d  = pos_q + POS_W'(1);
      step_d = 1'b1;
      dir_d  = DIR_FWD;
    end else if (bwd_i && (pos_q != '0)) begin
      pos_d  = pos_q - POS_W'(1);
      step_d = 1'b1;
      dir_d  = DIR_BWD;
    end
    if (clear_i) begin
      peak_d = '0;
    end else if (capture_i) begin
      peak_d = pos_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q  <= '0;
      peak_q <= '0;
      step_q <= 1'b0;
      dir_q  <= DIR_FWD;
    end else begin
      pos_q  <= pos_d;
      peak_q <= peak_d;
      step_q <= step_d;
      dir_q  <= dir_d;
    end
  end

  assign pos_o  = pos_q;
  assign peak_o = peak_q;
  assign step_o = step_q;
  assign dir_o  = dir_q;

endmodule

// File: rtl/sweep_scheduler.sv
// Sun-tracking sweep sequencer. Sweeps the horizontal then vertical servo,
// samples the panel voltage once per position after a settle delay, tracks the
// peak and drives each servo back to its peak position.
//   CLK, RST_N          : clock, async active-low reset
//   TICK                : step-rate strobe
//   START / ABORT       : begin sweep (IDLE only) / return to IDLE
//   ADC_SOC, ADC_EOC,
//   ADC_DATA            : conversion handshake and sample
//   STEP_H/V, DIR_H/V   : servo step pulses and directions
//   BUSY, DONE, ERR     : status (ERR = sticky EOC timeout)
//   MAX_V, MAX_H_POS,
//   MAX_V_POS           : peak sample and where it occurred
//   STAT                : current state code
module sweep_scheduler
  import sp_pkg::*;
#(
  parameter int unsigned ADC_W        = ADC_W_DEF,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned H_STEPS      = 180,
  parameter int unsigned V_STEPS      = 90,
  parameter int unsigned SETTLE_TICKS = 4,
  parameter int unsigned EOC_TIMEOUT  = 4095
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              TICK,
  input  logic              START,
  input  logic              ABORT,
  output logic              ADC_SOC,
  input  logic              ADC_EOC,
  input  logic [ADC_W-1:0]  ADC_DATA,
  output logic              STEP_H,
  output logic              STEP_V,
  output logic              DIR_H,
  output logic              DIR_V,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADC_W-1:0]  MAX_V,
  output logic [POS_W-1:0]  MAX_H_POS,
  output logic [POS_W-1:0]  MAX_V_POS,
  output logic [STAT_W-1:0] STAT
);

  localparam int unsigned SET_W = $clog2(SETTLE_TICKS + 1);
  localparam int unsigned TO_W  = $clog2(EOC_TIMEOUT + 1);

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(EOC_TIMEOUT - 1);
  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_STEPS - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_STEPS - 1);

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [ADC_W-1:0]   max_v_q, max_v_d;
  logic               err_q, err_d;
  logic               soc_q, soc_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [STAT_W-1:0]  stat_q;

  logic               fwd_h, bwd_h, fwd_v, bwd_v;
  logic               cap_h, cap_v, clr_peaks;
  logic [POS_W-1:0]   pos_h, peak_h, pos_v, peak_v;
  logic [POS_W-1:0]   cur_pos, cur_peak, cur_last;

  // Axis currently being swept.
  assign cur_pos  = (phase_q == PH_H) ? pos_h  : pos_v;
  assign cur_peak = (phase_q == PH_H) ? peak_h : peak_v;
  assign cur_last = (phase_q == PH_H) ? H_LAST : V_LAST;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      phase_q <= PH_H;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic; ABORT overrides every transition.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (ABORT) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_d = ST_SETTLE;
            phase_d = PH_H;
          end
        end
        ST_SETTLE: begin
          if (TICK && (set_cnt_q == SET_LAST)) state_d = ST_SAMPLE;
        end
        ST_SAMPLE: state_d = ST_WAIT_EOC;
        ST_WAIT_EOC: begin
          if (ADC_EOC) begin
            state_d = (cur_pos < cur_last) ? ST_STEP : ST_RETURN;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = ST_IDLE;
          end
        end
        ST_STEP: begin
          if (TICK) state_d = ST_SETTLE;
        end
        ST_RETURN: begin
          // Back at the peak: hand over to the vertical axis or finish.
          if (cur_pos == cur_peak) begin
            if (phase_q == PH_H) begin
              phase_d = PH_V;
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    soc_d     = (state_d == ST_SAMPLE);
    done_d    = (state_d == ST_FINISH);
    busy_d    = (state_d != ST_IDLE);
    err_d     = err_q;
    max_v_d   = max_v_q;
    set_cnt_d = set_cnt_q;
    to_cnt_d  = to_cnt_q;
    fwd_h     = 1'b0;
    bwd_h     = 1'b0;
    fwd_v     = 1'b0;
    bwd_v     = 1'b0;
    cap_h     = 1'b0;
    cap_v     = 1'b0;
    clr_peaks = 1'b0;
    if (!ABORT) begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            clr_peaks = 1'b1;
            err_d     = 1'b0;
            max_v_d   = '0;
            set_cnt_d = '0;
          end
        end
        ST_SETTLE: begin
          if (TICK) begin
            set_cnt_d = (set_cnt_q == SET_LAST) ? '0 : set_cnt_q + SET_W'(1);
          end
        end
        ST_SAMPLE: to_cnt_d = '0;
        ST_WAIT_EOC: begin
          if (ADC_EOC) begin
            // Strict compare: ties keep the earlier position.
            if (ADC_DATA > max_v_q) begin
              max_v_d = ADC_DATA;
              cap_h   = (phase_q == PH_H);
              cap_v   = (phase_q == PH_V);
            end
          end else if (to_cnt_q == TO_LAST) begin
            err_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_STEP: begin
          if (TICK) begin
            fwd_h     = (phase_q == PH_H);
            fwd_v     = (phase_q == PH_V);
            set_cnt_d = '0;
          end
        end
        ST_RETURN: begin
          if (cur_pos == cur_peak) begin
            set_cnt_d = '0;
          end else if (TICK) begin
            bwd_h = (phase_q == PH_H);
            bwd_v = (phase_q == PH_V);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      set_cnt_q <= '0;
      to_cnt_q  <= '0;
      max_v_q   <= '0;
      err_q     <= 1'b0;
      soc_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      stat_q    <= '0;
    end else begin
      set_cnt_q <= set_cnt_d;
      to_cnt_q  <= to_cnt_d;
      max_v_q   <= max_v_d;
      err_q     <= err_d;
      soc_q     <= soc_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      stat_q    <= state_d;
    end
  end

  axis_tracker #(
    .POS_W (POS_W),
    .STEPS (H_STEPS)
  ) u_axis_h (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .fwd_i     (fwd_h),
    .bwd_i     (bwd_h),
    .capture_i (cap_h),
    .clear_i   (clr_peaks),
    .pos_o     (pos_h),
    .peak_o    (peak_h),
    .step_o    (STEP_H),
    .dir_o     (DIR_H)
  );

  axis_tracker #(
    .POS_W (POS_W),
    .STEPS (V_STEPS)
  ) u_axis_v (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .fwd_i     (fwd_v),
    .bwd_i     (bwd_v),
    .capture_i (cap_v),
    .clear_i   (clr_peaks),
    .pos_o     (pos_v),
    .peak_o    (peak_v),
    .step_o    (STEP_V),
    .dir_o     (DIR_V)
  );

  assign ADC_SOC   = soc_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign MAX_V     = max_v_q;
  assign MAX_H_POS = peak_h;
  assign MAX_V_POS = peak_v;
  assign STAT      = stat_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler with a small sweep (4 x 3 positions).
module tb_sweep_scheduler;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned POS_W = 8;
  localparam int unsigned TO    = 30;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             TICK = 1'b0;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic             ADC_EOC = 1'b0;
  logic [ADC_W-1:0] ADC_DATA = '0;
  logic             ADC_SOC, STEP_H, STEP_V, DIR_H, DIR_V, BUSY, DONE, ERR;
  logic [ADC_W-1:0] MAX_V;
  logic [POS_W-1:0] MAX_H_POS, MAX_V_POS;
  logic [2:0]       STAT;

  int total = 0;
  int bad   = 0;

  int tick_div = 0;
  bit auto_adc = 1'b1;
  int soc_cnt = 0;
  int withhold_from = 1000;
  logic [ADC_W-1:0] adc_q[$];
  int fwd_h = 0, bwd_h = 0, fwd_v = 0, bwd_v = 0, done_cnt = 0;
  int h0;

  sweep_scheduler #(
    .ADC_W(ADC_W), .POS_W(POS_W), .H_STEPS(4), .V_STEPS(3),
    .SETTLE_TICKS(2), .EOC_TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .START(START), .ABORT(ABORT),
    .ADC_SOC(ADC_SOC), .ADC_EOC(ADC_EOC), .ADC_DATA(ADC_DATA),
    .STEP_H(STEP_H), .STEP_V(STEP_V), .DIR_H(DIR_H), .DIR_V(DIR_V),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .MAX_V(MAX_V),
    .MAX_H_POS(MAX_H_POS), .MAX_V_POS(MAX_V_POS), .STAT(STAT)
  );

  initial forever #5 CLK = ~CLK;

  // Step-rate strobe: one cycle in four.
  initial forever begin
    @(negedge CLK);
    tick_div = (tick_div + 1) % 4;
    TICK = (tick_div == 0);
  end

  // ADC model: answers each SOC three cycles later with the next queued sample.
  initial forever begin
    @(negedge CLK);
    if (ADC_SOC && auto_adc) begin
      soc_cnt++;
      if (soc_cnt < withhold_from) begin
        repeat (3) @(negedge CLK);
        ADC_DATA = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
        ADC_EOC  = 1'b1;
        @(negedge CLK);
        ADC_EOC  = 1'b0;
      end
    end
  end

  // Step / done pulse counters.
  initial forever begin
    @(negedge CLK);
    if (STEP_H && !DIR_H) fwd_h++;
    if (STEP_H &&  DIR_H) bwd_h++;
    if (STEP_V && !DIR_V) fwd_v++;
    if (STEP_V &&  DIR_V) bwd_v++;
    if (DONE) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      @(negedge CLK);
      n++;
    end
    total++;
    assert (!BUSY) else begin
      bad++;
      $error("FAIL %s: observed=busy expected=idle within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_stat(input string tag, input logic [2:0] code, input int budget);
    int n = 0;
    while (STAT !== code && n < budget) begin
      @(negedge CLK);
      n++;
    end
    total++;
    assert (STAT === code) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, STAT, code);
    end
  endtask

  task automatic clr_counts();
    fwd_h = 0; bwd_h = 0; fwd_v = 0; bwd_v = 0; done_cnt = 0; soc_cnt = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_stat", 32'(STAT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_maxv", 32'(MAX_V), 0);
    chk("rst_soc", 32'(ADC_SOC), 0);
    chk("rst_err", 32'(ERR), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // 1: peak in both axes, tie keeps earlier H position
    adc_q = '{12'd100, 12'd300, 12'd300, 12'd200, 12'd50, 12'd400, 12'd10};
    clr_counts();
    START = 1'b1; @(negedge CLK); START = 1'b0;
    chk("t1_busy", 32'(BUSY), 1);
    wait_idle("t1_idle", 3000);
    chk("t1_maxh", 32'(MAX_H_POS), 1);
    chk("t1_maxvp", 32'(MAX_V_POS), 1);
    chk("t1_maxv", 32'(MAX_V), 400);
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_bwdh", 32'(bwd_h), 2);
    chk("t1_bwdv", 32'(bwd_v), 1);
    chk("t1_fwdh", 32'(fwd_h), 3);
    chk("t1_fwdv", 32'(fwd_v), 2);
    chk("t1_err", 32'(ERR), 0);

    // 2: flat data, peaks stay at home
    do_reset();
    adc_q = '{12'd500, 12'd500, 12'd500, 12'd500, 12'd500, 12'd500, 12'd500};
    clr_counts();
    START = 1'b1; @(negedge CLK); START = 1'b0;
    wait_idle("t2_idle", 3000);
    chk("t2_maxh", 32'(MAX_H_POS), 0);
    chk("t2_maxvp", 32'(MAX_V_POS), 0);
    chk("t2_maxv", 32'(MAX_V), 500);
    chk("t2_bwdh", 32'(bwd_h), 3);
    chk("t2_bwdv", 32'(bwd_v), 2);
    chk("t2_done", 32'(done_cnt), 1);

    // 3: EOC withheld after the second SOC
    do_reset();
    adc_q = '{12'd100};
    clr_counts();
    withhold_from = 2;
    START = 1'b1; @(negedge CLK); START = 1'b0;
    wait_idle("t3_idle", 500);
    chk("t3_err", 32'(ERR), 1);
    chk("t3_stat", 32'(STAT), 0);
    chk("t3_busy", 32'(BUSY), 0);
    chk("t3_done", 32'(done_cnt), 0);
    chk("t3_maxv", 32'(MAX_V), 100);

    // 4: START clears ERR/MAX_V; ABORT in STEP; START+ABORT together
    withhold_from = 1000;
    adc_q = '{12'd700, 12'd700, 12'd700};
    clr_counts();
    START = 1'b1; @(negedge CLK); START = 1'b0;
    chk("t4_errclr", 32'(ERR), 0);
    chk("t4_maxvclr", 32'(MAX_V), 0);
    wait_stat("t4_step", 3'd4, 300);
    h0 = fwd_h;
    ABORT = 1'b1; @(negedge CLK); ABORT = 1'b0;
    chk("t4_ab_stat", 32'(STAT), 0);
    chk("t4_ab_busy", 32'(BUSY), 0);
    chk("t4_ab_steph", 32'(STEP_H), 0);
    repeat (3) @(negedge CLK);
    chk("t4_ab_nostep", 32'(fwd_h), 32'(h0));
    chk("t4_ab_maxv", 32'(MAX_V), 700);
    adc_q.delete();
    START = 1'b1; ABORT = 1'b1; @(negedge CLK); START = 1'b0; ABORT = 1'b0;
    chk("t4_sa_busy", 32'(BUSY), 0);
    chk("t4_sa_maxv", 32'(MAX_V), 700);
    START = 1'b1; @(negedge CLK); START = 1'b0;
    chk("t4_rs_maxv", 32'(MAX_V), 0);
    chk("t4_rs_busy", 32'(BUSY), 1);
    ABORT = 1'b1; @(negedge CLK); ABORT = 1'b0;
    chk("t4_rs_stat", 32'(STAT), 0);

    // 5: START while busy and EOC coincident with SOC are ignored
    do_reset();
    auto_adc = 1'b0;
    START = 1'b1; @(negedge CLK); START = 1'b0;
    wait_stat("t5_sample", 3'd2, 300);
    chk("t5_soc", 32'(ADC_SOC), 1);
    ADC_EOC = 1'b1; ADC_DATA = 12'd999; START = 1'b1;
    @(negedge CLK);
    ADC_EOC = 1'b0; START = 1'b0;
    chk("t5_soc_1clk", 32'(ADC_SOC), 0);
    chk("t5_wait", 32'(STAT), 3);
    chk("t5_maxv0", 32'(MAX_V), 0);
    repeat (2) @(negedge CLK);
    chk("t5_still_wait", 32'(STAT), 3);
    ADC_EOC = 1'b1; ADC_DATA = 12'd123;
    @(negedge CLK);
    ADC_EOC = 1'b0;
    chk("t5_maxv", 32'(MAX_V), 123);
    chk("t5_step", 32'(STAT), 4);
    chk("t5_maxh", 32'(MAX_H_POS), 0);

    // 6: asynchronous reset in WAIT_EOC
    wait_stat("t6_wait", 3'd3, 300);
    #3;
    RST_N = 1'b0;
    #1;
    chk("t6_stat", 32'(STAT), 0);
    chk("t6_busy", 32'(BUSY), 0);
    chk("t6_maxv", 32'(MAX_V), 0);
    chk("t6_soc", 32'(ADC_SOC), 0);
    chk("t6_steph", 32'(STEP_H), 0);
    chk("t6_dirh", 32'(DIR_H), 0);
    chk("t6_err", 32'(ERR), 0);
    chk("t6_done", 32'(DONE), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("t6_post_stat", 32'(STAT), 0);
    chk("t6_post_busy", 32'(BUSY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
